// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
//   Boot-time program loader. It pops bytes from a first-word-fall-through UART
//   RX FIFO and assembles them little-endian into instruction words. Each word
//   is written sequentially into instruction memory. A HALT_WORD (which is
//   itself written) or a full memory ends the load. One mode byte then selects
//   continuous run (0x00) or single-step (0x01); any other mode value is
//   ignored. In step mode every further byte yields one step pulse.
//
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous active-low reset
//   din          FIFO head byte (valid while empty = 0)
//   empty        FIFO empty flag
//   read_tx      FIFO pop strobe, one cycle per byte
//   finish_send  byte-consumed pulse, coincident with read_tx
//   wr_en        instruction-memory write enable
//   wr_addr      instruction-memory word address
//   wr_data      assembled instruction word
//   loaded       program load complete (halt seen or memory full)
//   overflow     memory filled without a halt word
//   en_pipeline  pipeline run enable (continuous mode)
//   step         one-cycle single-step pulse (step mode)
//   run_mode     0 = continuous, 1 = step
// -----------------------------------------------------------------------------
module instr_loader #(
    parameter int unsigned NB_DATA   = 32,
    parameter int unsigned NB_BYTE   = 8,
    parameter int unsigned NB_ADDR   = 7,
    parameter int unsigned MEM_DEPTH = 128,
    parameter logic [NB_DATA-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NB_BYTE-1:0] din,
    input  logic               empty,
    output logic               read_tx,
    output logic               finish_send,
    output logic               wr_en,
    output logic [NB_ADDR-1:0] wr_addr,
    output logic [NB_DATA-1:0] wr_data,
    output logic               loaded,
    output logic               overflow,
    output logic               en_pipeline,
    output logic               step,
    output logic               run_mode
);

    localparam int unsigned BYTES = NB_DATA / NB_BYTE;
    localparam int unsigned BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BCW-1:0]     BC_LAST   = BCW'(BYTES - 1);
    localparam logic [NB_ADDR-1:0] ADDR_LAST = NB_ADDR'(MEM_DEPTH - 1);

    typedef enum logic [2:0] {
        S_RX,
        S_ACK,
        S_WRITE,
        S_WAIT_MODE,
        S_MODE_ACK,
        S_RUN,
        S_RUN_ACK
    } state_t;

    state_t             r_state;
    logic [BCW-1:0]     r_byte_cnt;
    logic [NB_ADDR-1:0] r_addr;
    logic [NB_DATA-1:0] r_word;
    logic [NB_BYTE-1:0] r_mode_byte;
    logic               r_read_tx;
    logic               r_finish_send;
    logic               r_wr_en;
    logic               r_loaded;
    logic               r_overflow;
    logic               r_en_pipeline;
    logic               r_step;
    logic               r_run_mode;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= S_RX;
            r_byte_cnt    <= '0;
            r_addr        <= '0;
            r_word        <= '0;
            r_mode_byte   <= '0;
            r_read_tx     <= 1'b0;
            r_finish_send <= 1'b0;
            r_wr_en       <= 1'b0;
            r_loaded      <= 1'b0;
            r_overflow    <= 1'b0;
            r_en_pipeline <= 1'b0;
            r_step        <= 1'b0;
            r_run_mode    <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            r_read_tx     <= 1'b0;
            r_finish_send <= 1'b0;
            r_wr_en       <= 1'b0;
            r_step        <= 1'b0;

            case (r_state)
                S_RX: begin
                    if (!empty) begin
                        // Shifting in from the top lands byte 0 in bits
                        // [NB_BYTE-1:0] after BYTES pops, which is the same
                        // little-endian lane placement as indexing by
                        // byte_cnt, because every word fully replaces the
                        // register before it is written.
                        r_word        <= {din, r_word[NB_DATA-1:NB_BYTE]};
                        r_read_tx     <= 1'b1;
                        r_finish_send <= 1'b1;
                        r_state       <= S_ACK;
                    end
                end

                // Dead cycle: the FIFO pops here, so empty is not looked at.
                S_ACK: begin
                    if (r_byte_cnt == BC_LAST) begin
                        r_byte_cnt <= '0;
                        r_wr_en    <= 1'b1;
                        r_state    <= S_WRITE;
                    end else begin
                        r_byte_cnt <= r_byte_cnt + 1'b1;
                        r_state    <= S_RX;
                    end
                end

                // wr_en is high during this state; the halt word is written too.
                S_WRITE: begin
                    if (r_word == HALT_WORD) begin
                        r_loaded <= 1'b1;
                        r_state  <= S_WAIT_MODE;
                    end else if (r_addr == ADDR_LAST) begin
                        r_loaded   <= 1'b1;
                        r_overflow <= 1'b1;
                        r_state    <= S_WAIT_MODE;
                    end else begin
                        r_addr  <= r_addr + 1'b1;
                        r_state <= S_RX;
                    end
                end

                S_WAIT_MODE: begin
                    if (!empty) begin
                        r_mode_byte   <= din;
                        r_read_tx     <= 1'b1;
                        r_finish_send <= 1'b1;
                        r_state       <= S_MODE_ACK;
                    end
                end

                S_MODE_ACK: begin
                    if (r_mode_byte == NB_BYTE'(0)) begin
                        r_run_mode    <= 1'b0;
                        r_en_pipeline <= 1'b1;
                        r_state       <= S_RUN;
                    end else if (r_mode_byte == NB_BYTE'(1)) begin
                        r_run_mode <= 1'b1;
                        r_state    <= S_RUN;
                    end else begin
                        r_state <= S_WAIT_MODE;
                    end
                end

                // Bytes keep draining in both modes so the FIFO never jams.
                S_RUN: begin
                    if (!empty) begin
                        r_read_tx     <= 1'b1;
                        r_finish_send <= 1'b1;
                        r_state       <= S_RUN_ACK;
                    end
                end

                S_RUN_ACK: begin
                    r_step  <= r_run_mode;
                    r_state <= S_RUN;
                end

                default: r_state <= S_RX;
            endcase
        end
    end

    assign read_tx     = r_read_tx;
    assign finish_send = r_finish_send;
    assign wr_en       = r_wr_en;
    assign wr_addr     = r_addr;
    assign wr_data     = r_word;
    assign loaded      = r_loaded;
    assign overflow    = r_overflow;
    assign en_pipeline = r_en_pipeline;
    assign step        = r_step;
    assign run_mode    = r_run_mode;

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;

    localparam int unsigned DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  din   = 8'h00;
    logic        empty = 1'b1;
    logic        read_tx, finish_send, wr_en, loaded, overflow;
    logic        en_pipeline, step, run_mode;
    logic [6:0]  wr_addr;
    logic [31:0] wr_data;

    always #5 clock = ~clock;

    instr_loader #(
        .NB_DATA  (32),
        .NB_BYTE  (8),
        .NB_ADDR  (7),
        .MEM_DEPTH(DEPTH),
        .HALT_WORD(32'hFFFF_FFFF)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .din        (din),
        .empty      (empty),
        .read_tx    (read_tx),
        .finish_send(finish_send),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .loaded     (loaded),
        .overflow   (overflow),
        .en_pipeline(en_pipeline),
        .step       (step),
        .run_mode   (run_mode)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [7:0]  q[$];          // FIFO contents
    logic [7:0]  all_bytes[$];  // every byte sent since the last reset
    logic [6:0]  got_addr[$];
    logic [31:0] got_data[$];
    int unsigned n_pops, n_steps;
    logic        p_rd, p_step, p_en;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // FWFT FIFO: pop on the edge ending a read_tx cycle, present head at negedge.
    always @(posedge clock)
        if (reset && read_tx && q.size() > 0) void'(q.pop_front());

    always @(negedge clock) begin
        empty = (q.size() == 0);
        din   = (q.size() > 0) ? q[0] : 8'h00;
    end

    // Protocol monitor.
    always @(negedge clock) begin
        if (!reset) begin
            p_rd = 1'b0; p_step = 1'b0; p_en = 1'b0;
        end else begin
            if (read_tx || finish_send) check("finish_send_eq_read_tx", finish_send, read_tx);
            if (read_tx) begin
                n_pops++;
                check("read_tx_gap", p_rd, 1'b0);
            end
            if (wr_en) begin
                got_addr.push_back(wr_addr);
                got_data.push_back(wr_data);
                check("wr_latency", p_rd, 1'b1);
            end
            if (step) begin
                n_steps++;
                check("step_gap", p_step, 1'b0);
                check("step_after_pop", p_rd, 1'b1);
            end
            if (en_pipeline && !p_en) check("en_after_mode_pop", p_rd, 1'b1);
            p_rd = read_tx; p_step = step; p_en = en_pipeline;
        end
    end

    task automatic start();
        @(negedge clock);
        reset = 1'b0;
        q.delete(); all_bytes.delete(); got_addr.delete(); got_data.delete();
        n_pops = 0; n_steps = 0;
        repeat (2) @(negedge clock);
        check("reset_outputs", {read_tx, finish_send, wr_en, wr_addr, wr_data, loaded,
                                overflow, en_pipeline, step, run_mode}, '0);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input int unsigned gap);
        repeat (gap) @(negedge clock);
        q.push_back(b);
        all_bytes.push_back(b);
    endtask

    task automatic send_word(input logic [31:0] w, input int unsigned gap);
        for (int i = 0; i < 4; i++) send(w[8*i +: 8], gap);
    endtask

    // Reference: walk the byte stream with the loader's rules and compare.
    task automatic settle(input string tag);
        int unsigned t = 0;
        int unsigned idx = 0;
        int unsigned addr = 0;
        int unsigned n = all_bytes.size();
        int          mode = -1;
        int unsigned steps = 0;
        bit          done = 0, ld = 0, ov = 0;
        logic [31:0] w;
        logic [6:0]  ea[$];
        logic [31:0] ed[$];
        while (q.size() != 0 && t < 3000) begin
            @(negedge clock);
            t++;
        end
        check({tag, "_drain"}, q.size() == 0, 1'b1);
        repeat (8) @(negedge clock);

        while (!done && idx + 4 <= n) begin
            w = {all_bytes[idx+3], all_bytes[idx+2], all_bytes[idx+1], all_bytes[idx]};
            idx += 4;
            ea.push_back(7'(addr));
            ed.push_back(w);
            if (w == 32'hFFFF_FFFF) begin
                done = 1; ld = 1;
            end else if (addr == DEPTH - 1) begin
                done = 1; ld = 1; ov = 1;
            end else begin
                addr++;
            end
        end
        if (done) begin
            while (idx < n && mode < 0) begin
                if (all_bytes[idx] == 8'h00) mode = 0;
                else if (all_bytes[idx] == 8'h01) mode = 1;
                idx++;
            end
            if (mode == 1) steps = n - idx;
        end

        check({tag, "_nwrites"}, got_data.size(), ed.size());
        for (int i = 0; i < ed.size() && i < got_data.size(); i++) begin
            check({tag, "_wr_addr"}, got_addr[i], ea[i]);
            check({tag, "_wr_data"}, got_data[i], ed[i]);
        end
        check({tag, "_loaded"}, loaded, ld);
        check({tag, "_overflow"}, overflow, ov);
        check({tag, "_en_pipeline"}, en_pipeline, mode == 0);
        check({tag, "_run_mode"}, run_mode, mode == 1);
        check({tag, "_pops"}, n_pops, n);
        check({tag, "_steps"}, n_steps, steps);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Single word.
        start();
        send_word(32'h8023_0000, 0);
        settle("one_word");

        // Program + step mode + three step bytes.
        start();
        send_word(32'h8023_0000, 0);
        send_word(32'h00E2_1821, 1);
        send_word(32'h0106_2821, 0);
        send_word(32'hFFFF_FFFF, 2);
        send(8'h01, 0);
        settle("step_mode");
        send(8'hA5, 0); send(8'h00, 3); send(8'h01, 1);
        settle("step_pulses");

        // Continuous mode, then a discarded byte.
        start();
        send_word(32'h8023_0000, 0);
        send_word(32'hFFFF_FFFF, 0);
        send(8'h00, 0);
        settle("cont_mode");
        send(8'h3C, 0);
        settle("cont_discard");

        // Junk mode byte is ignored.
        start();
        send_word(32'hFFFF_FFFF, 0);
        send(8'h07, 0);
        settle("junk_mode");
        send(8'h00, 0);
        settle("junk_then_cont");

        // Memory fills without halt; trailing bytes act as ignored mode bytes.
        start();
        for (int i = 0; i < 16; i++) send(8'(8'h11 * (i + 1)), 0);
        send(8'h55, 0); send(8'h66, 0);
        settle("overflow");

        // Reset in the middle of a word.
        start();
        send(8'hDE, 0); send(8'hAD, 0);
        settle("partial");
        start();
        send_word(32'h1234_5678, 0);
        settle("after_reset");

        // Randomized programs.
        for (int it = 0; it < 40; it++) begin
            int unsigned nw = $urandom_range(1, DEPTH + 1);
            start();
            for (int k = 0; k < nw; k++)
                send_word(($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom()),
                          $urandom_range(0, 2));
            for (int k = $urandom_range(0, 2); k > 0; k--)
                send(8'($urandom_range(2, 255)), $urandom_range(0, 3));
            if ($urandom_range(0, 4) != 0) send(8'($urandom_range(0, 1)), $urandom_range(0, 3));
            for (int k = $urandom_range(0, 3); k > 0; k--)
                send(8'($urandom()), $urandom_range(0, 3));
            settle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
